// File: rtl/hdmi_cfg_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdmi_cfg_seq : walks the HDMI TX register table as I2C write requests,   |
// |                with NACK/timeout retry and sticky done/error reporting    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module hdmi_cfg_seq #(
  parameter logic [7:0]  DEV_ADDR       = 8'h72,
  parameter logic [23:0] STARTUP_CYCLES = 24'd838000,
  parameter logic [1:0]  MAX_RETRY      = 2'd3,
  parameter logic [15:0] RETRY_GAP      = 16'd4190,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       req_valid,
  output logic [7:0] req_dev,
  output logic [7:0] req_reg,
  output logic [7:0] req_data,
  input  logic       req_ready,
  input  logic       rsp_valid,
  input  logic       rsp_ack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] index
);

  localparam logic [2:0]  S_IDLE     = 3'd0;
  localparam logic [2:0]  S_DELAY    = 3'd1;
  localparam logic [2:0]  S_ISSUE    = 3'd2;
  localparam logic [2:0]  S_WAIT     = 3'd3;
  localparam logic [2:0]  S_GAP      = 3'd4;
  localparam logic [2:0]  S_DONE     = 3'd5;
  localparam logic [2:0]  S_ERROR    = 3'd6;
  localparam logic [3:0]  LAST_INDEX = 4'd12;
  localparam logic [15:0] ENTRY0     = 16'h4110;

  logic [2:0]  state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [1:0]  retry_q, retry_d;
  logic [23:0] cnt_q, cnt_d;
  logic        req_valid_q, req_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  req_reg_q, req_reg_d;
  logic [7:0]  req_data_q, req_data_d;
  logic        timeout_w, ack_w, fail_w;

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h4110;
      4'd1:    table_entry = 16'h9803;
      4'd2:    table_entry = 16'h9AE0;
      4'd3:    table_entry = 16'h9C30;
      4'd4:    table_entry = 16'h9D61;
      4'd5:    table_entry = 16'hA2A4;
      4'd6:    table_entry = 16'hA3A4;
      4'd7:    table_entry = 16'hE0D0;
      4'd8:    table_entry = 16'hF900;
      4'd9:    table_entry = 16'h1500;
      4'd10:   table_entry = 16'h1630;
      4'd11:   table_entry = 16'h1702;
      4'd12:   table_entry = 16'hAF06;
      default: table_entry = ENTRY0;
    endcase
  endfunction

  // cnt_q counts completed WAIT cycles; a response in the expiring cycle wins
  assign timeout_w = (cnt_q + 24'd1) >= {8'd0, TIMEOUT_CYCLES};
  assign ack_w     = (state_q == S_WAIT) && rsp_valid && rsp_ack;
  assign fail_w    = (state_q == S_WAIT) && (rsp_valid ? !rsp_ack : timeout_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                 <= S_IDLE;
      index_q                 <= 4'd0;
      retry_q                 <= 2'd0;
      cnt_q                   <= 24'd0;
      req_valid_q             <= 1'b0;
      busy_q                  <= 1'b0;
      done_q                  <= 1'b0;
      error_q                 <= 1'b0;
      {req_reg_q, req_data_q} <= ENTRY0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      req_reg_q   <= req_reg_d;
      req_data_q  <= req_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          index_d = 4'd0;
          retry_d = 2'd0;
          if (STARTUP_CYCLES == 24'd0) begin
            state_d = S_ISSUE;
            cnt_d   = 24'd0;
          end else begin
            state_d = S_DELAY;
            cnt_d   = STARTUP_CYCLES - 24'd1;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == 24'd0) state_d = S_ISSUE;
        else                cnt_d   = cnt_q - 24'd1;
      end
      S_ISSUE: begin
        if (req_valid_q && req_ready) begin
          state_d = S_WAIT;
          cnt_d   = 24'd0;
        end
      end
      S_WAIT: begin
        if (ack_w) begin
          if (index_q == LAST_INDEX) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 4'd1;
            retry_d = 2'd0;
            state_d = S_ISSUE;
          end
        end else if (fail_w) begin
          if (retry_q >= MAX_RETRY) begin
            state_d = S_ERROR;
          end else begin
            retry_d = retry_q + 2'd1;
            if (RETRY_GAP == 16'd0) begin
              state_d = S_ISSUE;
            end else begin
              state_d = S_GAP;
              cnt_d   = {8'd0, RETRY_GAP} - 24'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 24'd0) state_d = S_ISSUE;
        else                cnt_d   = cnt_q - 24'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they leave the flops aligned with state_q
  always_comb begin
    req_valid_d             = (state_d == S_ISSUE);
    busy_d                  = (state_d == S_DELAY) || (state_d == S_ISSUE) ||
                              (state_d == S_WAIT)  || (state_d == S_GAP);
    done_d                  = (state_d == S_DONE);
    error_d                 = (state_d == S_ERROR);
    {req_reg_d, req_data_d} = table_entry(index_d);
  end

  assign req_valid = req_valid_q;
  assign req_dev   = DEV_ADDR;
  assign req_reg   = req_reg_q;
  assign req_data  = req_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign index     = index_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_cfg_seq.sv
`default_nettype none
// tb_hdmi_cfg_seq : table-driven scenarios against an I2C master model,
// with a queue of expected write requests checked at every handshake.
module tb_hdmi_cfg_seq;

  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       req_valid;
  logic [7:0] req_dev, req_reg, req_data;
  logic       req_ready;
  logic       rsp_valid, rsp_ack;
  logic       busy, done, error;
  logic [3:0] index;

  hdmi_cfg_seq #(
    .DEV_ADDR      (8'h72),
    .STARTUP_CYCLES(24'd4),
    .MAX_RETRY     (2'd3),
    .RETRY_GAP     (16'd2),
    .TIMEOUT_CYCLES(16'd10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .req_valid(req_valid),
    .req_dev  (req_dev),
    .req_reg  (req_reg),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ack  (rsp_ack),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .index    (index)
  );

  always #5 clk = ~clk;

  logic [7:0] c_reg [13] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2, 8'hA3,
                             8'hE0, 8'hF9, 8'h15, 8'h16, 8'h17, 8'hAF};
  logic [7:0] c_dat [13] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4, 8'hA4,
                             8'hD0, 8'h00, 8'h00, 8'h30, 8'h02, 8'h06};

  typedef struct {
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
  } txn_t;

  typedef struct {
    string name;
    int nack_e, nack_n, sil_e, sil_n, stall_e, stall_n, tie_e;
    bit exp_done, exp_err;
    int exp_idx, exp_hs, chk_e, exp_iss, exp_lat, exp_stall;
  } vec_t;

  txn_t exp_q[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  // master model state
  int nack_left[13], sil_left[13], stall_left[13], issues[13], rise_lat[13];
  bit hs_seen[13];
  int tie_e = -1, stall_e = -1, hs_cnt = 0, stall_ok = 0;
  int ncyc = 0, last_hs = -1000, rsp_cd = -1;
  bit pend_ack = 1'b0, prev_valid = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // I2C master: decides req_ready / rsp at negedge for the following posedge
  always @(negedge clk) begin
    int   idx;
    txn_t t;
    ncyc++;
    rsp_valid = 1'b0;
    rsp_ack   = 1'b0;
    req_ready = 1'b0;
    if (rst) begin
      rsp_cd = -1;
    end else begin
      if (rsp_cd > 0) begin
        rsp_cd--;
        if (rsp_cd == 0) begin
          rsp_valid = 1'b1;
          rsp_ack   = pend_ack;
          rsp_cd    = -1;
        end
      end
      if (req_valid) begin
        idx = int'(index);
        if (idx > 12) idx = 12;
        if (!prev_valid) rise_lat[idx] = ncyc - last_hs;
        if (stall_left[idx] > 0) begin
          stall_left[idx]--;
          if (stall_e >= 0 && req_dev == 8'h72 &&
              req_reg == c_reg[stall_e] && req_data == c_dat[stall_e])
            stall_ok++;
        end else begin
          req_ready = 1'b1;
          hs_cnt++;
          issues[idx]++;
          hs_seen[idx] = 1'b1;
          last_hs = ncyc;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_req", {8'h0, req_dev, req_reg, req_data}, -1);
          end else begin
            t = exp_q.pop_front();
            check($sformatf("sb_req@%0d", hs_cnt), {8'h0, req_dev, req_reg, req_data},
                  {8'h0, t.dev, t.rg, t.dat});
          end
          if (sil_left[idx] > 0) begin
            sil_left[idx]--;
            rsp_cd = -1;
          end else if (idx == tie_e) begin
            tie_e    = -1;
            pend_ack = 1'b1;
            rsp_cd   = 10;
          end else begin
            pend_ack = (nack_left[idx] == 0);
            if (nack_left[idx] > 0) nack_left[idx]--;
            rsp_cd = 3;
          end
        end
      end
    end
    prev_valid = req_valid;
  end

  task automatic cfg_vec(input vec_t v);
    int fails, att;
    for (int e = 0; e < 13; e++) begin
      nack_left[e]  = (e == v.nack_e)  ? v.nack_n  : 0;
      sil_left[e]   = (e == v.sil_e)   ? v.sil_n   : 0;
      stall_left[e] = (e == v.stall_e) ? v.stall_n : 0;
      issues[e]     = 0;
      rise_lat[e]   = -1;
      hs_seen[e]    = 1'b0;
    end
    tie_e    = v.tie_e;
    stall_e  = v.stall_e;
    hs_cnt   = 0;
    stall_ok = 0;
    exp_q.delete();
    for (int e = 0; e < 13; e++) begin
      fails = nack_left[e] + sil_left[e];
      att   = (fails > MAXR) ? MAXR + 1 : fails + 1;
      for (int a = 0; a < att; a++) exp_q.push_back('{8'h72, c_reg[e], c_dat[e]});
      if (fails > MAXR) break;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit poke);
    int k, n, quiet;
    cfg_vec(v);
    @(negedge clk);
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      start = poke && (k == 2);
    end while (!req_valid && k < 50);
    start = 1'b0;
    check({v.name, ".start_lat"}, k, 5);
    n = 0;
    while (!(done || error) && n < 3000) begin
      @(negedge clk);
      n++;
      start = poke && (n == 40);
    end
    start = 1'b0;
    check({v.name, ".finished_in_budget"}, int'(n < 3000), 1);
    check({v.name, ".done"},   int'(done),  int'(v.exp_done));
    check({v.name, ".error"},  int'(error), int'(v.exp_err));
    check({v.name, ".busy"},   int'(busy),  0);
    check({v.name, ".index"},  int'(index), v.exp_idx);
    check({v.name, ".requests"}, hs_cnt, v.exp_hs);
    check($sformatf("%s.issues[%0d]", v.name, v.chk_e), issues[v.chk_e], v.exp_iss);
    check($sformatf("%s.rise_lat[%0d]", v.name, v.chk_e), rise_lat[v.chk_e], v.exp_lat);
    check({v.name, ".stall_stable_cycles"}, stall_ok, v.exp_stall);
    check({v.name, ".sb_left"}, exp_q.size(), 0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_valid) quiet++;
    end
    check({v.name, ".quiet_after_end"}, quiet, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t rv;
    int   n, quiet;
    // name, nack_e/n, sil_e/n, stall_e/n, tie_e, done, err, idx, hs, chk_e, iss, lat, stall
    vecs[0] = '{"clean",   -1, 0, -1, 0, -1,  0, -1, 1, 0, 12, 13,  1, 1,  4,  0};
    vecs[1] = '{"stall3",  -1, 0, -1, 0,  3, 20, -1, 1, 0, 12, 13,  3, 1,  4, 20};
    vecs[2] = '{"nack5x2",  5, 2, -1, 0, -1,  0, -1, 1, 0, 12, 15,  5, 3,  6,  0};
    vecs[3] = '{"nack7x4",  7, 4, -1, 0, -1,  0, -1, 0, 1,  7, 11,  7, 4,  6,  0};
    vecs[4] = '{"tmo0",    -1, 0,  0, 1, -1,  0, -1, 1, 0, 12, 14,  0, 2, 13,  0};
    vecs[5] = '{"tie0",    -1, 0, -1, 0, -1,  0,  0, 1, 0, 12, 13,  1, 1, 11,  0};
    vecs[6] = '{"tmo12x4", -1, 0, 12, 4, -1,  0, -1, 0, 1, 12, 16, 12, 4, 13,  0};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.ctrl", {busy, done, error, req_valid, index}, 0);
    check("reset.fields", {8'h0, req_dev, req_reg, req_data}, 32'h00724110);
    #3 rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

    // asynchronous reset while entry 9 is waiting for its response
    rv = vecs[0];
    rv.name  = "rst_wait9";
    rv.sil_e = 9;
    rv.sil_n = 1;
    cfg_vec(rv);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!hs_seen[9] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait9.reached", int'(hs_seen[9]), 1);
    repeat (3) @(negedge clk);
    check("rst_wait9.in_wait", {busy, req_valid, index}, {1'b1, 1'b0, 4'd9});
    #1 rst = 1'b1;
    #1;
    check("rst_wait9.ctrl_async", {busy, done, error, req_valid, index}, 0);
    check("rst_wait9.fields_async", {8'h0, req_dev, req_reg, req_data}, 32'h00724110);
    @(negedge clk);
    #3 rst = 1'b0;
    exp_q.delete();
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_valid || busy) quiet++;
    end
    check("rst_wait9.idle_after", quiet, 0);

    // restart after reset, with start pulsed during DELAY and mid-sequence
    rv = vecs[0];
    rv.name = "start_busy";
    run_vec(rv, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
`default_nettype wire
